// File: rtl/rot_issue_ctrl_pkg.sv
// rtl/rot_issue_ctrl_pkg.sv - shared constants and request record for the rotator issue stage
package rot_issue_ctrl_pkg;

  localparam int ROT_NBIT            = 8;
  localparam int ROT_SBIT            = 3;
  localparam int ROT_FIFO_DEPTH_LOG2 = 2;

  typedef struct packed {
    logic [ROT_NBIT-1:0] data;
    logic [ROT_SBIT-1:0] amt;
  } rot_req_t;

endpackage

// File: rtl/rot_issue_ctrl_if.sv
// rtl/rot_issue_ctrl_if.sv - request handshake and rotator-facing signals of the issue stage
interface rot_issue_ctrl_if
  import rot_issue_ctrl_pkg::*;
#(
  parameter int NBIT       = ROT_NBIT,
  parameter int SBIT       = ROT_SBIT,
  parameter int DEPTH_LOG2 = ROT_FIFO_DEPTH_LOG2
);

  logic                  i_req_vld;
  logic                  o_req_rdy;
  logic [NBIT-1:0]       i_req_data;
  logic [SBIT-1:0]       i_req_amt;
  logic [NBIT-1:0]       o_a;
  logic [SBIT-1:0]       o_sel;
  logic                  o_res_vld;
  logic [DEPTH_LOG2:0]   o_count;
  logic                  o_busy;

  modport slave (
    input  i_req_vld, i_req_data, i_req_amt,
    output o_req_rdy, o_a, o_sel, o_res_vld, o_count, o_busy
  );

  modport master (
    output i_req_vld, i_req_data, i_req_amt,
    input  o_req_rdy, o_a, o_sel, o_res_vld, o_count, o_busy
  );

endinterface

// File: rtl/rot_req_fifo.sv
// rtl/rot_req_fifo.sv - synchronous request FIFO with registered count, no bypass paths
module rot_req_fifo #(
  parameter int WIDTH      = 11,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count alone distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/rot_issue_ctrl.sv
// rtl/rot_issue_ctrl.sv - issue stage that feeds the registered-stage rotator with skewed selects
module rot_issue_ctrl
  import rot_issue_ctrl_pkg::*;
#(
  parameter int NBIT       = ROT_NBIT,
  parameter int SBIT       = ROT_SBIT,
  parameter int DEPTH_LOG2 = ROT_FIFO_DEPTH_LOG2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  rot_issue_ctrl_if.slave  bus
);

  logic [NBIT+SBIT-1:0] wdata;
  logic [NBIT+SBIT-1:0] rdata;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic [DEPTH_LOG2:0]  count;
  logic [NBIT-1:0]      a_q;
  logic [SBIT:0]        vld_q;
  logic [SBIT-1:0]      sel;

  assign wdata = {bus.i_req_data, bus.i_req_amt};
  // The rotator never stalls, so any queued entry issues on the next edge.
  assign pop   = ~empty;

  rot_req_fifo #(
    .WIDTH      (NBIT + SBIT),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (i_clk),
    .rstn  (i_rstn),
    .push  (bus.i_req_vld),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      a_q   <= '0;
      vld_q <= '0;
    end else begin
      a_q   <= pop ? rdata[NBIT+SBIT-1:SBIT] : '0;
      vld_q <= {vld_q[SBIT-1:0], pop};
    end
  end

  // Select bit j is consumed by rotator stage SBIT-1-j, so it is delayed that many cycles.
  for (genvar j = 0; j < SBIT; j++) begin : g_skew
    localparam int K = SBIT - 1 - j;
    logic [K:0] sh;

    always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
        sh <= '0;
      end else begin
        sh[0] <= pop & rdata[j];
        for (int d = 1; d <= K; d++) begin
          sh[d] <= sh[d-1];
        end
      end
    end

    assign sel[j] = sh[K];
  end

  assign bus.o_req_rdy = ~full;
  assign bus.o_count   = count;
  assign bus.o_a       = a_q;
  assign bus.o_sel     = sel;
  assign bus.o_res_vld = vld_q[SBIT];
  assign bus.o_busy    = (count != '0) | (|vld_q);

endmodule

// File: tb/tb_rot_issue_ctrl.sv
// tb/tb_rot_issue_ctrl.sv - randomized bench for rot_issue_ctrl against a queue-based reference model
module tb_rot_issue_ctrl;
  import rot_issue_ctrl_pkg::*;

  localparam int NB    = ROT_NBIT;
  localparam int SB    = ROT_SBIT;
  localparam int DEPTH = 1 << ROT_FIFO_DEPTH_LOG2;
  localparam int MAXC  = 4096;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  rot_issue_ctrl_if bus ();

  rot_issue_ctrl dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  function automatic logic [NB-1:0] rotr(input logic [NB-1:0] d, input logic [SB-1:0] n);
    logic [2*NB-1:0] w;
    w = {d, d} >> n;
    return w[NB-1:0];
  endfunction

  // Downstream registered-stage rotator: stage s uses select bit SB-1-s, one cycle per stage.
  logic [NB-1:0] s0, s1, y;
  always @(posedge clk) begin
    s0 <= rotr(bus.o_a, bus.o_sel[2] ? 3'd4 : 3'd0);
    s1 <= rotr(s0,      bus.o_sel[1] ? 3'd2 : 3'd0);
    y  <= rotr(s1,      bus.o_sel[0] ? 3'd1 : 3'd0);
  end

  rot_req_t      q[$];
  bit [NB-1:0]   exp_a   [MAXC];
  bit [SB-1:0]   exp_sel [MAXC];
  bit            exp_vld [MAXC];
  bit [NB-1:0]   exp_y   [MAXC];
  int            cyc;
  int            last_issue;
  int            checks;
  int            failures;
  bit            hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    chk("count",   32'(bus.o_count),   32'(q.size()));
    chk("req_rdy", 32'(bus.o_req_rdy), 32'(q.size() < DEPTH));
    chk("busy",    32'(bus.o_busy),    32'((q.size() != 0) || (cyc - last_issue <= SB)));
    chk("a",       32'(bus.o_a),       32'(exp_a[cyc]));
    chk("sel",     32'(bus.o_sel),     32'(exp_sel[cyc]));
    chk("res_vld", 32'(bus.o_res_vld), 32'(exp_vld[cyc]));
    if (exp_vld[cyc]) chk("y", 32'(y), 32'(exp_y[cyc]));
  endtask

  task automatic model_edge(input bit rv, input bit v, input logic [NB-1:0] d,
                            input logic [SB-1:0] am, input bit hv);
    rot_req_t r;
    bit       p;
    bit       acc;
    if (!rv) begin
      q.delete();
      for (int k = cyc + 1; k <= cyc + SB + 1; k++) begin
        exp_a[k] = '0; exp_sel[k] = '0; exp_vld[k] = 1'b0; exp_y[k] = '0;
      end
      last_issue = -100;
    end else begin
      p   = (q.size() != 0) && !hv;
      acc = v && (q.size() < DEPTH);
      if (p) begin
        r = q.pop_front();
        exp_a[cyc+1] = r.data;
        for (int j = 0; j < SB; j++) begin
          if (r.amt[j]) exp_sel[cyc + 1 + SB - 1 - j][j] = 1'b1;
        end
        exp_vld[cyc+1+SB] = 1'b1;
        exp_y[cyc+1+SB]   = rotr(r.data, r.amt);
        last_issue = cyc + 1;
      end
      if (acc) q.push_back('{data: d, amt: am});
    end
  endtask

  task automatic step(input bit rv, input bit v, input logic [NB-1:0] d,
                      input logic [SB-1:0] am);
    check_cycle();
    rstn           = rv;
    bus.i_req_vld  = v;
    bus.i_req_data = d;
    bus.i_req_amt  = am;
    if (hold) force dut.pop = 1'b0;
    else      release dut.pop;
    model_edge(rv, v, d, am, hold);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    checks = 0; failures = 0; hold = 1'b0; last_issue = -100;
    bus.i_req_vld = 1'b0; bus.i_req_data = '0; bus.i_req_amt = '0;
    repeat (2) @(posedge clk);
    cyc = 2;
    @(negedge clk);

    idle(10);

    step(1'b1, 1'b1, 8'h81, 3'd1);
    idle(6);

    step(1'b1, 1'b1, 8'h01, 3'd7);
    step(1'b1, 1'b1, 8'h80, 3'd0);
    step(1'b1, 1'b1, 8'hF0, 3'd5);
    step(1'b1, 1'b1, 8'h3C, 3'd2);
    idle(7);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, NB'($urandom), SB'($urandom));
    idle(6);

    hold = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, NB'(8'hA0 + i), SB'(i));
    step(1'b1, 1'b1, 8'h55, 3'd3);
    hold = 1'b0;
    idle(10);

    step(1'b1, 1'b1, 8'h11, 3'd1);
    step(1'b1, 1'b1, 8'h22, 3'd2);
    step(1'b0, 1'b1, 8'h33, 3'd3);
    idle(7);

    step(1'b1, 1'b1, 8'hC3, 3'd6);
    idle(1);
    step(1'b1, 1'b1, 8'h5A, 3'd3);
    step(1'b1, 1'b1, 8'hE1, 3'd4);
    idle(7);

    for (int i = 0; i < 400; i++) begin
      if (hold) hold = ($urandom_range(0, 99) >= 30);
      else      hold = ($urandom_range(0, 99) < 5);
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 70),
           NB'($urandom), SB'($urandom));
    end
    hold = 1'b0;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
